// File: rtl/inst_mem.sv
// Instruction memory: registered single-cycle fetch for the PC, plus a byte-serial
// boot-load port that fills the array big-endian, one word per four bytes.
module inst_mem #(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter logic [31:0] NOP_WORD   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ce,
    input  logic [31:0] addr,
    output logic [31:0] inst,
    output logic        inst_valid,
    output logic        addr_err,
    input  logic        ld_start,
    input  logic        ld_valid,
    input  logic [7:0]  ld_byte,
    input  logic        ld_last,
    output logic        ld_ready,
    output logic        busy,
    output logic        ld_overflow
);

    localparam int unsigned DEPTH   = 1 << ADDR_WIDTH;
    localparam int unsigned PTR_W   = ADDR_WIDTH + 1;
    localparam int unsigned HI_LSB  = ADDR_WIDTH + 2;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_LOAD = 1'b1;

    logic [0:0]            r_state;
    logic [0:0]            w_next_state;

    logic [31:0]           r_mem [DEPTH];

    logic [23:0]           r_word_buf;
    logic [1:0]            r_byte_cnt;
    logic [PTR_W-1:0]      r_word_ptr;
    logic                  r_overflow;
    logic                  r_busy;
    logic [31:0]           r_inst;
    logic                  r_inst_valid;
    logic                  r_addr_err;

    logic                  w_xfer;
    logic                  w_word_done;
    logic                  w_full;
    logic                  w_mem_we;
    logic [31:0]           w_wr_data;
    logic                  w_misaligned;
    logic                  w_out_of_range;
    logic [ADDR_WIDTH-1:0] w_rd_idx;

    assign w_xfer         = (r_state == ST_LOAD) && ld_valid;
    assign w_word_done    = w_xfer && (ld_last || (r_byte_cnt == 2'd3));
    // Pointer saturates at DEPTH, so its MSB alone flags "array full".
    assign w_full         = r_word_ptr[ADDR_WIDTH];
    assign w_mem_we       = w_word_done && !w_full && !reset;
    assign w_misaligned   = (addr[1:0] != 2'b00);
    assign w_out_of_range = ((addr >> HI_LSB) != 32'd0);
    assign w_rd_idx       = addr[ADDR_WIDTH+1:2];

    // Assemble the outgoing word, zero-padding the low bytes of a short final word.
    always_comb begin
        w_wr_data = 32'd0;
        case (r_byte_cnt)
            2'd0:    w_wr_data = {ld_byte, 24'd0};
            2'd1:    w_wr_data = {r_word_buf[7:0], ld_byte, 16'd0};
            2'd2:    w_wr_data = {r_word_buf[15:0], ld_byte, 8'd0};
            default: w_wr_data = {r_word_buf, ld_byte};
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (ld_start) begin
                    w_next_state = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (w_xfer && ld_last) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Memory array write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[r_word_ptr[ADDR_WIDTH-1:0]] <= w_wr_data;
        end
    end

    // Load datapath and registered fetch outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_word_buf   <= 24'd0;
            r_byte_cnt   <= 2'd0;
            r_word_ptr   <= '0;
            r_overflow   <= 1'b0;
            r_busy       <= 1'b0;
            r_inst       <= NOP_WORD;
            r_inst_valid <= 1'b0;
            r_addr_err   <= 1'b0;
        end else begin
            r_busy <= (w_next_state == ST_LOAD);
            if (r_state == ST_IDLE) begin
                if (ld_start) begin
                    r_word_buf <= 24'd0;
                    r_byte_cnt <= 2'd0;
                    r_word_ptr <= '0;
                    r_overflow <= 1'b0;
                end
                if (!ce) begin
                    r_inst       <= NOP_WORD;
                    r_inst_valid <= 1'b0;
                    r_addr_err   <= 1'b0;
                end else if (w_misaligned || w_out_of_range) begin
                    r_inst       <= NOP_WORD;
                    r_inst_valid <= 1'b0;
                    r_addr_err   <= 1'b1;
                end else begin
                    r_inst       <= r_mem[w_rd_idx];
                    r_inst_valid <= 1'b1;
                    r_addr_err   <= 1'b0;
                end
            end else begin
                r_inst       <= NOP_WORD;
                r_inst_valid <= 1'b0;
                r_addr_err   <= 1'b0;
                if (w_word_done) begin
                    r_word_buf <= 24'd0;
                    r_byte_cnt <= 2'd0;
                    if (w_full) begin
                        r_overflow <= 1'b1;
                    end else begin
                        r_word_ptr <= r_word_ptr + PTR_W'(1);
                    end
                end else if (w_xfer) begin
                    r_word_buf <= {r_word_buf[15:0], ld_byte};
                    r_byte_cnt <= r_byte_cnt + 2'd1;
                end
            end
        end
    end

    assign inst        = r_inst;
    assign inst_valid  = r_inst_valid;
    assign addr_err    = r_addr_err;
    assign ld_ready    = r_busy;
    assign busy        = r_busy;
    assign ld_overflow = r_overflow;

endmodule

// File: tb/tb_inst_mem.sv
// Directed bench for inst_mem: a default-depth instance and a 4-word instance share
// all inputs; the small one is only checked in the final overflow scenario.
module tb_inst_mem;

    logic        clk = 1'b0;
    logic        reset, ce, ld_start, ld_valid, ld_last;
    logic [31:0] addr;
    logic [7:0]  ld_byte;

    logic [31:0] inst, s_inst;
    logic        inst_valid, addr_err, ld_ready, busy, ld_overflow;
    logic        s_inst_valid, s_addr_err, s_ld_ready, s_busy, s_ld_overflow;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [7:0]  img [0:31];

    always #5 clk = ~clk;

    inst_mem #(.ADDR_WIDTH(10), .NOP_WORD(32'h0000_0000)) dut (
        .clk(clk), .reset(reset), .ce(ce), .addr(addr),
        .inst(inst), .inst_valid(inst_valid), .addr_err(addr_err),
        .ld_start(ld_start), .ld_valid(ld_valid), .ld_byte(ld_byte), .ld_last(ld_last),
        .ld_ready(ld_ready), .busy(busy), .ld_overflow(ld_overflow)
    );

    inst_mem #(.ADDR_WIDTH(2), .NOP_WORD(32'h0000_0000)) dut_s (
        .clk(clk), .reset(reset), .ce(ce), .addr(addr),
        .inst(s_inst), .inst_valid(s_inst_valid), .addr_err(s_addr_err),
        .ld_start(ld_start), .ld_valid(ld_valid), .ld_byte(ld_byte), .ld_last(ld_last),
        .ld_ready(s_ld_ready), .busy(s_busy), .ld_overflow(s_ld_overflow)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse ld_start, stream img[0..n-1]; optional idle gap before byte `gap`,
    // optional stray ld_start on byte `start_mid` (must be ignored).
    task automatic do_load(input int n, input int gap, input int start_mid);
        ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
        check("load_busy", 32'(busy), 32'd1);
        check("load_ready", 32'(ld_ready), 32'd1);
        for (int i = 0; i < n; i++) begin
            if (i == gap) begin
                ld_valid = 1'b0;
                tick();
            end
            ld_valid = 1'b1;
            ld_byte  = img[i];
            ld_last  = (i == n - 1);
            ld_start = (i == start_mid);
            tick();
        end
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        ld_start = 1'b0;
        check("busy_fall", 32'(busy), 32'd0);
    endtask

    task automatic fetch(input logic [31:0] a);
        ce   = 1'b1;
        addr = a;
        tick();
    endtask

    initial begin
        reset = 1'b1; ce = 1'b0; addr = 32'd0;
        ld_start = 1'b0; ld_valid = 1'b0; ld_last = 1'b0; ld_byte = 8'd0;
        tick();
        tick();
        check("rst_inst", inst, 32'h0);
        check("rst_valid", 32'(inst_valid), 32'd0);
        check("rst_err", 32'(addr_err), 32'd0);
        check("rst_ready", 32'(ld_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ovf", 32'(ld_overflow), 32'd0);
        reset = 1'b0;
        tick();

        // Single-word load, then fetch it back.
        img[0] = 8'h3C; img[1] = 8'h01; img[2] = 8'h12; img[3] = 8'h34;
        do_load(4, -1, -1);
        fetch(32'h0);
        check("f0_inst", inst, 32'h3C01_1234);
        check("f0_valid", 32'(inst_valid), 32'd1);
        check("f0_err", 32'(addr_err), 32'd0);
        ce = 1'b0;
        tick();
        check("ce0_inst", inst, 32'h0);
        check("ce0_valid", 32'(inst_valid), 32'd0);

        // Address errors.
        fetch(32'h0000_0002);
        check("mis_err", 32'(addr_err), 32'd1);
        check("mis_inst", inst, 32'h0);
        check("mis_valid", 32'(inst_valid), 32'd0);
        fetch(32'h0000_1000);
        check("oor_err", 32'(addr_err), 32'd1);
        check("oor_valid", 32'(inst_valid), 32'd0);
        fetch(32'h8000_0000);
        check("oor_hi_err", 32'(addr_err), 32'd1);
        fetch(32'h0000_0FFC);
        check("top_err", 32'(addr_err), 32'd0);
        check("top_valid", 32'(inst_valid), 32'd1);
        ce = 1'b0;

        // Six-byte load with a valid gap and a stray ld_start mid-load.
        img[0] = 8'h11; img[1] = 8'h22; img[2] = 8'h33;
        img[3] = 8'h44; img[4] = 8'h55; img[5] = 8'h66;
        do_load(6, 2, 4);
        fetch(32'h0);
        check("w0_inst", inst, 32'h1122_3344);
        fetch(32'h4);
        check("w1_inst", inst, 32'h5566_0000);

        // ld_start with ce in the same cycle: fetch is still served.
        addr = 32'h4; ce = 1'b1; ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
        check("startce_inst", inst, 32'h5566_0000);
        check("startce_valid", 32'(inst_valid), 32'd1);
        check("startce_busy", 32'(busy), 32'd1);
        addr = 32'h2;
        ld_valid = 1'b1; ld_byte = 8'hAA;
        tick();
        check("ld_fetch_inst", inst, 32'h0);
        check("ld_fetch_valid", 32'(inst_valid), 32'd0);
        check("ld_fetch_err", 32'(addr_err), 32'd0);
        ld_byte = 8'hBB;
        tick();
        ld_valid = 1'b0;

        // Reset mid-load: abort, contents retained, fetch resumes.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_ready", 32'(ld_ready), 32'd0);
        fetch(32'h0);
        check("keep_w0", inst, 32'h1122_3344);
        check("keep_valid", 32'(inst_valid), 32'd1);
        fetch(32'h4);
        check("keep_w1", inst, 32'h5566_0000);
        ce = 1'b0;

        // Short final word is zero-padded.
        img[0] = 8'hAA; img[1] = 8'hBB;
        do_load(2, -1, -1);
        fetch(32'h0);
        check("pad_inst", inst, 32'hAABB_0000);
        ce = 1'b0;

        // 20-byte image into the 4-word instance: overflow, no wrap.
        for (int i = 0; i < 20; i++) img[i] = 8'(i + 1);
        do_load(20, -1, -1);
        check("s_ovf", 32'(s_ld_overflow), 32'd1);
        check("s_busy", 32'(s_busy), 32'd0);
        check("big_ovf", 32'(ld_overflow), 32'd0);
        fetch(32'h0);
        check("s_w0", s_inst, 32'h0102_0304);
        check("big_w0", inst, 32'h0102_0304);
        fetch(32'h4);
        check("s_w1", s_inst, 32'h0506_0708);
        fetch(32'h8);
        check("s_w2", s_inst, 32'h090A_0B0C);
        fetch(32'hC);
        check("s_w3", s_inst, 32'h0D0E_0F10);
        check("s_ovf_sticky", 32'(s_ld_overflow), 32'd1);
        fetch(32'h10);
        check("s_oor_err", 32'(s_addr_err), 32'd1);
        check("big_w4", inst, 32'h1112_1314);
        ce = 1'b0;
        ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
        check("s_ovf_clr", 32'(s_ld_overflow), 32'd0);
        ld_valid = 1'b1; ld_last = 1'b1; ld_byte = 8'h00;
        tick();
        ld_valid = 1'b0; ld_last = 1'b0;
        check("end_busy", 32'(busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
